// File: rtl/axis_pkg.sv
// Shared constants for the AXI4-Stream slave stage: occupancy encodings and default widths.
package axis_pkg;

    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_CNT_W  = 32;

    // One-hot occupancy of the two-entry skid buffer
    localparam logic [2:0] OCC_EMPTY = 3'b001;
    localparam logic [2:0] OCC_ONE   = 3'b010;
    localparam logic [2:0] OCC_TWO   = 3'b100;

endpackage

// File: rtl/axis_slave_fifo_writer_skid.sv
// Two-entry registered skid buffer. in_ready is derived only from flops, so the
// downstream pop (which depends on fifo_full) never reaches in_ready combinationally.
module axis_skid_buffer
    import axis_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_pop
);

    logic [2:0]        state_q, state_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              main_last_q, main_last_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              skid_last_q, skid_last_d;
    logic              in_fire;

    assign in_ready  = ready_q & (state_q != OCC_TWO);
    assign in_fire   = in_valid & in_ready;
    assign out_valid = (state_q != OCC_EMPTY);
    assign out_data  = main_data_q;
    assign out_last  = main_last_q;

    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b1;
        main_data_d = main_data_q;
        main_last_d = main_last_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        case (state_q)
            OCC_EMPTY: begin
                if (in_fire) begin
                    state_d     = OCC_ONE;
                    main_data_d = in_data;
                    main_last_d = in_last;
                end
            end
            OCC_ONE: begin
                if (in_fire && out_pop) begin
                    main_data_d = in_data;
                    main_last_d = in_last;
                end else if (in_fire) begin
                    state_d     = OCC_TWO;
                    skid_data_d = in_data;
                    skid_last_d = in_last;
                end else if (out_pop) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                // in_ready is low here, so only a pop can move the buffer
                if (out_pop) begin
                    state_d     = OCC_ONE;
                    main_data_d = skid_data_q;
                    main_last_d = skid_last_q;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= OCC_EMPTY;
            ready_q     <= 1'b0;
            main_data_q <= '0;
            main_last_q <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            main_data_q <= main_data_d;
            main_last_q <= main_last_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
        end
    end

endmodule

// File: rtl/axis_slave_fifo_writer.sv
// AXI4-Stream slave feeding a FIFO write port through a skid buffer, with
// wrapping beat/packet counters of words actually written.
module axis_slave_fifo_writer
    import axis_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = AXIS_DATA_W,
    parameter int C_CNT_WIDTH          = AXIS_CNT_W
) (
    input  logic                            S_AXIS_ACLK,
    input  logic                            S_AXIS_ARESETN,
    input  logic                            S_AXIS_TVALID,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                            S_AXIS_TLAST,
    output logic                            S_AXIS_TREADY,
    output logic                            fifo_wr_en,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0] fifo_wr_data,
    output logic                            fifo_wr_last,
    input  logic                            fifo_full,
    output logic [C_CNT_WIDTH-1:0]          beat_count,
    output logic [C_CNT_WIDTH-1:0]          pkt_count
);

    logic                   buf_valid;
    logic [C_CNT_WIDTH-1:0] beat_count_q, beat_count_d;
    logic [C_CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;

    axis_skid_buffer #(
        .DATA_W (C_S_AXIS_TDATA_WIDTH)
    ) u_skid (
        .clk       (S_AXIS_ACLK),
        .rst_n     (S_AXIS_ARESETN),
        .in_valid  (S_AXIS_TVALID),
        .in_data   (S_AXIS_TDATA),
        .in_last   (S_AXIS_TLAST),
        .in_ready  (S_AXIS_TREADY),
        .out_valid (buf_valid),
        .out_data  (fifo_wr_data),
        .out_last  (fifo_wr_last),
        .out_pop   (fifo_wr_en)
    );

    // The only combinational input-to-output path in the block
    assign fifo_wr_en = buf_valid & ~fifo_full;

    always_comb begin
        beat_count_d = beat_count_q;
        pkt_count_d  = pkt_count_q;
        if (fifo_wr_en) begin
            beat_count_d = beat_count_q + C_CNT_WIDTH'(1);
            if (fifo_wr_last)
                pkt_count_d = pkt_count_q + C_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            beat_count_q <= '0;
            pkt_count_q  <= '0;
        end else begin
            beat_count_q <= beat_count_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign beat_count = beat_count_q;
    assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_axis_slave_fifo_writer.sv
// Randomized self-checking bench: accepted beats must come out of the FIFO port
// in order, once each, with counters tracking words written.
module tb_axis_slave_fifo_writer;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tvalid = 1'b0;
    logic [DW-1:0] tdata = '0;
    logic          tlast = 1'b0;
    logic          tready;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          wr_last;
    logic          full = 1'b0;
    logic [CW-1:0] beat_count;
    logic [CW-1:0] pkt_count;

    int checks = 0;
    int errors = 0;
    int exp_beats = 0;
    int exp_pkts = 0;
    int en_full_cnt = 0;

    logic [DW:0] acc_log[$];
    logic [DW:0] wr_log[$];

    axis_slave_fifo_writer #(
        .C_S_AXIS_TDATA_WIDTH (DW),
        .C_CNT_WIDTH          (CW)
    ) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (rst_n),
        .S_AXIS_TVALID  (tvalid),
        .S_AXIS_TDATA   (tdata),
        .S_AXIS_TLAST   (tlast),
        .S_AXIS_TREADY  (tready),
        .fifo_wr_en     (wr_en),
        .fifo_wr_data   (wr_data),
        .fifo_wr_last   (wr_last),
        .fifo_full      (full),
        .beat_count     (beat_count),
        .pkt_count      (pkt_count)
    );

    always #5 clk = ~clk;

    // Passive observer: logs handshakes that will complete on the next rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (tvalid && tready) acc_log.push_back({tlast, tdata});
            if (wr_en) wr_log.push_back({wr_last, wr_data});
            if (wr_en && full) en_full_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] wrap(input int v);
        return CW'(v % (1 << CW));
    endfunction

    task automatic check_counts(input string name);
        checks++;
        if (beat_count !== wrap(exp_beats) || pkt_count !== wrap(exp_pkts)) begin
            errors++;
            $display("FAIL %s counters: got beat=%0d pkt=%0d expected beat=%0d pkt=%0d",
                     name, beat_count, pkt_count, wrap(exp_beats), wrap(exp_pkts));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({tready, wr_en, wr_data, wr_last, beat_count, pkt_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got tready=%b wr_en=%b data=%h last=%b beat=%0d pkt=%0d expected all 0",
                     tready, wr_en, wr_data, wr_last, beat_count, pkt_count);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_pre_edge tready: got %b expected 0", tready);
        end
        step();
        checks++;
        if (tready !== 1'b1 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_post_edge: got tready=%b wr_en=%b expected 1 0", tready, wr_en);
        end
        exp_beats = 0;
        exp_pkts = 0;
    endtask

    task automatic test_stream();
        logic [DW-1:0] vals[3];
        vals = '{32'h11, 32'h22, 32'h33};
        full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tvalid = 1'b1;
            tdata = vals[i];
            tlast = (i == 2);
            checks++;
            if (tready !== 1'b1) begin
                errors++;
                $display("FAIL stream_tready beat %0d: got %b expected 1", i, tready);
            end
            step();
            checks++;
            if (wr_en !== 1'b1 || wr_data !== vals[i] || wr_last !== (i == 2)) begin
                errors++;
                $display("FAIL stream_write beat %0d: got en=%b data=%h last=%b expected 1 %h %b",
                         i, wr_en, wr_data, wr_last, vals[i], (i == 2));
            end
        end
        tvalid = 1'b0;
        tlast = 1'b0;
        step();
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL stream_idle wr_en: got %b expected 0", wr_en);
        end
        exp_beats += 3;
        exp_pkts += 1;
        check_counts("stream");
    endtask

    task automatic test_backpressure();
        int base;
        base = wr_log.size();
        full = 1'b1;
        tvalid = 1'b1;
        tlast = 1'b0;
        tdata = 32'hA1;
        step();
        tdata = 32'hA2;
        checks++;
        if (tready !== 1'b1 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_one: got tready=%b wr_en=%b expected 1 0", tready, wr_en);
        end
        step();
        tdata = 32'hA3;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tready !== 1'b0 || wr_en !== 1'b0 || wr_data !== 32'hA1) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got tready=%b wr_en=%b data=%h expected 0 0 a1",
                         i, tready, wr_en, wr_data);
            end
            step();
        end
        full = 1'b0;
        #1;
        checks++;
        if (wr_en !== 1'b1 || tready !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got wr_en=%b tready=%b expected 1 0", wr_en, tready);
        end
        step();
        checks++;
        if (tready !== 1'b1 || wr_data !== 32'hA2) begin
            errors++;
            $display("FAIL bp_ready_return: got tready=%b data=%h expected 1 a2", tready, wr_data);
        end
        step();
        tvalid = 1'b0;
        repeat (3) step();
        checks++;
        if (wr_log.size() - base != 3 ||
            wr_log[base] !== {1'b0, 32'hA1} || wr_log[base+1] !== {1'b0, 32'hA2} ||
            wr_log[base+2] !== {1'b0, 32'hA3}) begin
            errors++;
            $display("FAIL bp_order: got %0d writes expected a1,a2,a3", wr_log.size() - base);
        end
        exp_beats += 3;
        check_counts("backpressure");
    endtask

    task automatic test_random();
        logic [DW:0] sent[$];
        int base, abase, cyc, bad_idx;
        base = wr_log.size();
        abase = acc_log.size();
        sent.push_back({1'($urandom_range(0, 1)), 32'($urandom)});
        {tlast, tdata} = sent[0];
        tvalid = 1'b1;
        cyc = 0;
        while (acc_log.size() - abase < 1000 && cyc < 6000) begin
            full = ~full;
            step();
            cyc++;
            if (acc_log.size() - abase == sent.size()) begin
                if (sent.size() < 1000) begin
                    sent.push_back({1'($urandom_range(0, 1)), 32'($urandom)});
                    {tlast, tdata} = sent[sent.size()-1];
                end else begin
                    tvalid = 1'b0;
                end
            end
        end
        tvalid = 1'b0;
        full = 1'b0;
        repeat (4) step();
        checks++;
        if (cyc >= 6000) begin
            errors++;
            $display("FAIL random_timeout: accepted %0d of 1000 beats", acc_log.size() - abase);
        end
        bad_idx = -1;
        for (int i = 0; i < sent.size(); i++) begin
            if (base + i >= wr_log.size() || wr_log[base+i] !== sent[i]) begin
                bad_idx = i;
                break;
            end
        end
        checks++;
        if (wr_log.size() - base != sent.size() || bad_idx >= 0) begin
            errors++;
            $display("FAIL random_scoreboard: got %0d writes first bad index %0d expected %0d in order",
                     wr_log.size() - base, bad_idx, sent.size());
        end
        checks++;
        if (en_full_cnt != 0) begin
            errors++;
            $display("FAIL wr_en_while_full: got %0d cycles expected 0", en_full_cnt);
        end
        foreach (sent[i]) begin
            exp_beats++;
            if (sent[i][DW]) exp_pkts++;
        end
        check_counts("random");
    endtask

    task automatic test_wrap();
        test_reset();
        full = 1'b0;
        tvalid = 1'b1;
        tlast = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tdata = 32'($urandom);
            step();
        end
        tvalid = 1'b0;
        step();
        exp_beats = 15;
        exp_pkts = 15;
        checks++;
        if (beat_count !== 4'd15) begin
            errors++;
            $display("FAIL wrap_preload beat_count: got %0d expected 15", beat_count);
        end
        tvalid = 1'b1;
        step();
        tvalid = 1'b0;
        step();
        checks++;
        if (beat_count !== 4'd0 || pkt_count !== 4'd0) begin
            errors++;
            $display("FAIL wrap_rollover: got beat=%0d pkt=%0d expected 0 0", beat_count, pkt_count);
        end
        exp_beats = 16;
        exp_pkts = 16;
        tlast = 1'b0;
    endtask

    task automatic test_reset_mid();
        int base;
        full = 1'b1;
        tvalid = 1'b1;
        tdata = 32'hB1;
        step();
        tdata = 32'hB2;
        step();
        checks++;
        if (tready !== 1'b0) begin
            errors++;
            $display("FAIL mid_two_full tready: got %b expected 0", tready);
        end
        full = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (wr_en !== 1'b0 || tready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: got wr_en=%b tready=%b expected 0 0", wr_en, tready);
        end
        tvalid = 1'b0;
        base = wr_log.size();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (5) step();
        exp_beats = 0;
        exp_pkts = 0;
        checks++;
        if (wr_log.size() != base) begin
            errors++;
            $display("FAIL mid_stale_writes: got %0d writes expected 0", wr_log.size() - base);
        end
        check_counts("reset_mid");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
